pio_ctrl: RTL and testbench

Host-facing control and configuration block for a PIO with four `machine` instances. It decodes a simple word-addressed register bus and holds each machine's configuration: clock divider, program wrap, jump pin, shift direction and pin mappings. It drives per-machine enable and a sequenced restart (reset pulse), and forwards program words to the shared instruction memory write port. It sits between the host interconnect and the four machines plus instruction RAM.

---
 rtl/pio_pkg.sv | 50 +++++
 rtl/sm_restart_seq.sv | 58 +++++
 rtl/pio_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pio_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register map, field positions and restart FSM encoding for pio_ctrl
package pio_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_STATUS     = 8'h01;
  localparam logic [7:0] ADDR_SM_BASE    = 8'h08;
  localparam logic [7:0] ADDR_SM_END     = 8'h18;
  localparam logic [7:0] ADDR_INSTR_BASE = 8'h20;

  localparam int SM_STRIDE = 4;
  localparam logic [1:0] OFF_CLKDIV   = 2'd0;
  localparam logic [1:0] OFF_EXECCTRL = 2'd1;
  localparam logic [1:0] OFF_PINCTRL  = 2'd2;

  localparam int CTRL_ENABLE_LSB  = 0;
  localparam int CTRL_RESTART_LSB = 4;

  localparam int EXEC_PSTART_LSB = 0;
  localparam int EXEC_PEND_LSB   = 5;
  localparam int EXEC_JMP_LSB    = 10;
  localparam int EXEC_SHIFT_BIT  = 15;

  localparam int PIN_OUT_BASE_LSB  = 0;
  localparam int PIN_OUT_CNT_LSB   = 5;
  localparam int PIN_SET_BASE_LSB  = 8;
  localparam int PIN_SET_CNT_LSB   = 13;
  localparam int PIN_IN_BASE_LSB   = 16;
  localparam int PIN_IN_CNT_LSB    = 21;
  localparam int PIN_SIDE_BASE_LSB = 24;
  localparam int PIN_SIDE_CNT_LSB  = 29;

  localparam logic [23:0] CLKDIV_RESET = 24'd1;
  localparam logic [15:0] EXEC_RESET   = 16'h03E0;

  typedef enum logic [1:0] {
    RST_IDLE    = 2'd0,
    RST_HOLD    = 2'd1,
    RST_RELEASE = 2'd2
  } restart_state_t;

  // A divider of 0 would stall the machine, so it is stored as 1.
  function automatic logic [23:0] clkdiv_sanitize(input logic [23:0] v);
    return (v == 24'd0) ? 24'd1 : v;
  endfunction

  function automatic logic is_instr_addr(input logic [7:0] a);
    return a[7:5] == ADDR_INSTR_BASE[7:5];
  endfunction

endpackage

// File: rtl/sm_restart_seq.sv
// rtl/sm_restart_seq.sv - per-machine restart sequencer: hold reset, one release cycle, back to idle
module sm_restart_seq
  import pio_pkg::*;
#(
  parameter int RESET_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_idle,
  output logic o_busy,
  output logic o_sm_reset
);

  localparam logic [3:0] CNT_LOAD = 4'(RESET_CYCLES - 1);

  restart_state_t r_state;
  restart_state_t w_state_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Start requests outside IDLE are dropped so a sequence can never be stretched.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_idle      = 1'b0;
    o_busy      = 1'b1;
    o_sm_reset  = 1'b0;
    case (r_state)
      RST_IDLE: begin
        o_idle = 1'b1;
        o_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = RST_HOLD;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      RST_HOLD: begin
        o_sm_reset = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = RST_RELEASE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      RST_RELEASE: w_state_nxt = RST_IDLE;
      default:     w_state_nxt = RST_IDLE;
    endcase
  end

endmodule

// File: rtl/pio_ctrl.sv
// rtl/pio_ctrl.sv - PIO host register file, machine enables/restarts and instruction write port
module pio_ctrl
  import pio_pkg::*;
#(
  parameter int NUM_SM       = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bus_cs,
  input  logic                 bus_we,
  input  logic [7:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ack,
  output logic                 imem_we,
  output logic [4:0]           imem_waddr,
  output logic [15:0]          imem_wdata,
  output logic [NUM_SM-1:0]    sm_en,
  output logic [NUM_SM-1:0]    sm_reset,
  output logic [NUM_SM*24-1:0] sm_div,
  output logic [NUM_SM*5-1:0]  sm_pstart,
  output logic [NUM_SM*5-1:0]  sm_pend,
  output logic [NUM_SM*5-1:0]  sm_jmp_pin_sel,
  output logic [NUM_SM-1:0]    sm_shift_dir,
  output logic [NUM_SM*5-1:0]  sm_out_base,
  output logic [NUM_SM*5-1:0]  sm_set_base,
  output logic [NUM_SM*5-1:0]  sm_in_base,
  output logic [NUM_SM*5-1:0]  sm_side_base,
  output logic [NUM_SM*3-1:0]  sm_out_count,
  output logic [NUM_SM*3-1:0]  sm_set_count,
  output logic [NUM_SM*3-1:0]  sm_in_count,
  output logic [NUM_SM*3-1:0]  sm_side_count
);

  logic [NUM_SM-1:0] r_enable;
  logic [23:0]       r_div  [NUM_SM];
  logic [15:0]       r_exec [NUM_SM];
  logic [31:0]       r_pin  [NUM_SM];

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_imem_we;
  logic [4:0]  r_imem_waddr;
  logic [15:0] r_imem_wdata;

  logic              w_wr;
  logic              w_rd;
  logic              w_ctrl_wr;
  logic              w_imem_hit;
  logic              w_sm_hit;
  logic [1:0]        w_sm_idx;
  logic [1:0]        w_sm_off;
  logic [31:0]       w_rd_data;
  logic [NUM_SM-1:0] w_restart_start;
  logic [NUM_SM-1:0] w_idle;
  logic [NUM_SM-1:0] w_busy;
  logic [NUM_SM-1:0] w_sm_reset;

  assign w_wr       = bus_cs & bus_we;
  assign w_rd       = bus_cs & ~bus_we;
  assign w_ctrl_wr  = w_wr & (bus_addr == ADDR_CTRL);
  assign w_imem_hit = w_wr & is_instr_addr(bus_addr);
  assign w_sm_hit   = (bus_addr >= ADDR_SM_BASE) && (bus_addr < ADDR_SM_END);
  // Within 0x08..0x17, addr[4:2] runs 2..5, so {addr[4], addr[2]} is the machine index.
  assign w_sm_idx   = {bus_addr[4], bus_addr[2]};
  assign w_sm_off   = bus_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        r_div[i]  <= CLKDIV_RESET;
        r_exec[i] <= EXEC_RESET;
        r_pin[i]  <= 32'd0;
      end
    end else if (w_wr) begin
      if (bus_addr == ADDR_CTRL) r_enable <= bus_wdata[CTRL_ENABLE_LSB +: NUM_SM];
      if (w_sm_hit) begin
        case (w_sm_off)
          OFF_CLKDIV:   r_div[w_sm_idx]  <= clkdiv_sanitize(bus_wdata[23:0]);
          OFF_EXECCTRL: r_exec[w_sm_idx] <= bus_wdata[15:0];
          OFF_PINCTRL:  r_pin[w_sm_idx]  <= bus_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_data = 32'd0;
    if (bus_addr == ADDR_CTRL) begin
      w_rd_data[CTRL_ENABLE_LSB +: NUM_SM] = r_enable;
    end else if (bus_addr == ADDR_STATUS) begin
      w_rd_data[NUM_SM-1:0] = w_busy;
    end else if (w_sm_hit) begin
      case (w_sm_off)
        OFF_CLKDIV:   w_rd_data = {8'd0, r_div[w_sm_idx]};
        OFF_EXECCTRL: w_rd_data = {16'd0, r_exec[w_sm_idx]};
        OFF_PINCTRL:  w_rd_data = r_pin[w_sm_idx];
        default:      w_rd_data = 32'd0;
      endcase
    end
  end

  // Every request is acked next cycle; rdata is forced to 0 outside a read ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack        <= 1'b0;
      r_rdata      <= 32'd0;
      r_imem_we    <= 1'b0;
      r_imem_waddr <= 5'd0;
      r_imem_wdata <= 16'd0;
    end else begin
      r_ack        <= bus_cs;
      r_rdata      <= w_rd ? w_rd_data : 32'd0;
      r_imem_we    <= w_imem_hit;
      r_imem_waddr <= w_imem_hit ? bus_addr[4:0] : 5'd0;
      r_imem_wdata <= w_imem_hit ? bus_wdata[15:0] : 16'd0;
    end
  end

  assign bus_ack    = r_ack;
  assign bus_rdata  = r_rdata;
  assign imem_we    = r_imem_we;
  assign imem_waddr = r_imem_waddr;
  assign imem_wdata = r_imem_wdata;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    assign w_restart_start[g] = w_ctrl_wr & bus_wdata[CTRL_RESTART_LSB + g];

    sm_restart_seq #(
      .RESET_CYCLES(RESET_CYCLES)
    ) u_restart (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_start    (w_restart_start[g]),
      .o_idle     (w_idle[g]),
      .o_busy     (w_busy[g]),
      .o_sm_reset (w_sm_reset[g])
    );

    assign sm_div[g*24 +: 24]        = r_div[g];
    assign sm_pstart[g*5 +: 5]       = r_exec[g][EXEC_PSTART_LSB +: 5];
    assign sm_pend[g*5 +: 5]         = r_exec[g][EXEC_PEND_LSB +: 5];
    assign sm_jmp_pin_sel[g*5 +: 5]  = r_exec[g][EXEC_JMP_LSB +: 5];
    assign sm_shift_dir[g]           = r_exec[g][EXEC_SHIFT_BIT];
    assign sm_out_base[g*5 +: 5]     = r_pin[g][PIN_OUT_BASE_LSB +: 5];
    assign sm_out_count[g*3 +: 3]    = r_pin[g][PIN_OUT_CNT_LSB +: 3];
    assign sm_set_base[g*5 +: 5]     = r_pin[g][PIN_SET_BASE_LSB +: 5];
    assign sm_set_count[g*3 +: 3]    = r_pin[g][PIN_SET_CNT_LSB +: 3];
    assign sm_in_base[g*5 +: 5]      = r_pin[g][PIN_IN_BASE_LSB +: 5];
    assign sm_in_count[g*3 +: 3]     = r_pin[g][PIN_IN_CNT_LSB +: 3];
    assign sm_side_base[g*5 +: 5]    = r_pin[g][PIN_SIDE_BASE_LSB +: 5];
    assign sm_side_count[g*3 +: 3]   = r_pin[g][PIN_SIDE_CNT_LSB +: 3];
  end

  // Enable stays masked for the whole restart, including the release cycle.
  assign sm_en    = r_enable & w_idle;
  assign sm_reset = w_sm_reset;

endmodule

// File: tb/tb_pio_ctrl.sv
// tb/tb_pio_ctrl.sv - directed self-checking bench for pio_ctrl
module tb_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_cs;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic [3:0]  sm_en;
  logic [3:0]  sm_reset;
  logic [95:0] sm_div;
  logic [19:0] sm_pstart, sm_pend, sm_jmp_pin_sel;
  logic [3:0]  sm_shift_dir;
  logic [19:0] sm_out_base, sm_set_base, sm_in_base, sm_side_base;
  logic [11:0] sm_out_count, sm_set_count, sm_in_count, sm_side_count;

  int n_vec = 0;
  int n_err = 0;

  pio_ctrl #(.NUM_SM(4), .RESET_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .sm_en(sm_en), .sm_reset(sm_reset), .sm_div(sm_div),
    .sm_pstart(sm_pstart), .sm_pend(sm_pend), .sm_jmp_pin_sel(sm_jmp_pin_sel),
    .sm_shift_dir(sm_shift_dir),
    .sm_out_base(sm_out_base), .sm_set_base(sm_set_base),
    .sm_in_base(sm_in_base), .sm_side_base(sm_side_base),
    .sm_out_count(sm_out_count), .sm_set_count(sm_set_count),
    .sm_in_count(sm_in_count), .sm_side_count(sm_side_count)
  );

  always #5 clk = ~clk;

  // Called just after a negedge: request occupies this cycle (T); returns mid T+1.
  task automatic bus_op(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic ack, output logic [31:0] rdata);
    bus_cs = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    @(negedge clk);
    ack = bus_ack; rdata = bus_rdata;
    bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 8'h00; bus_wdata = 32'd0;
  endtask

  task automatic test_reset;
    logic ack; logic [31:0] rd;
    reset = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 8'h00; bus_wdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_vec++; if (bus_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %h want 0", bus_ack); end
    n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus_rdata); end
    n_vec++; if ({imem_we, imem_waddr, imem_wdata} !== 22'd0) begin n_err++; $display("FAIL reset_imem: got %h/%h/%h want 0", imem_we, imem_waddr, imem_wdata); end
    n_vec++; if (sm_en !== 4'h0 || sm_reset !== 4'h0) begin n_err++; $display("FAIL reset_en_rst: got en %h rst %h want 0 0", sm_en, sm_reset); end
    n_vec++; if (sm_div !== {4{24'd1}}) begin n_err++; $display("FAIL reset_div: got %h want all 1", sm_div); end
    n_vec++; if (sm_pend !== {4{5'd31}} || sm_pstart !== 20'd0) begin n_err++; $display("FAIL reset_wrap: got pend %h pstart %h", sm_pend, sm_pstart); end
    n_vec++; if (sm_side_count !== 12'd0 || sm_in_base !== 20'd0) begin n_err++; $display("FAIL reset_pin: got %h %h want 0", sm_side_count, sm_in_base); end
    bus_op(1'b0, 8'h10, 32'd0, ack, rd);
    n_vec++; if (ack !== 1'b1 || rd !== 32'h0000_0001) begin n_err++; $display("FAIL rd_clkdiv2: got ack %h data %h want 1 00000001", ack, rd); end
    bus_op(1'b0, 8'h09, 32'd0, ack, rd);
    n_vec++; if (ack !== 1'b1 || rd !== 32'h0000_03E0) begin n_err++; $display("FAIL rd_exec0: got ack %h data %h want 1 000003e0", ack, rd); end
    @(negedge clk);
    n_vec++; if (bus_ack !== 1'b0 || bus_rdata !== 32'd0) begin n_err++; $display("FAIL idle_ack: got ack %h data %h want 0 0", bus_ack, bus_rdata); end
  endtask

  task automatic test_instr;
    logic ack; logic [31:0] rd;
    bus_op(1'b1, 8'h25, 32'h0000_E081, ack, rd);
    n_vec++; if (ack !== 1'b1 || imem_we !== 1'b1 || imem_waddr !== 5'd5 || imem_wdata !== 16'hE081) begin
      n_err++; $display("FAIL instr_wr: got ack %h we %h addr %h data %h want 1 1 05 e081", ack, imem_we, imem_waddr, imem_wdata); end
    bus_op(1'b1, 8'h3F, 32'hABCD_1234, ack, rd);
    n_vec++; if (imem_we !== 1'b1 || imem_waddr !== 5'd31 || imem_wdata !== 16'h1234) begin
      n_err++; $display("FAIL instr_b2b: got we %h addr %h data %h want 1 1f 1234", imem_we, imem_waddr, imem_wdata); end
    bus_op(1'b0, 8'h25, 32'd0, ack, rd);
    n_vec++; if (imem_we !== 1'b0 || ack !== 1'b1 || rd !== 32'd0) begin
      n_err++; $display("FAIL instr_rd: got we %h ack %h data %h want 0 1 0", imem_we, ack, rd); end
  endtask

  task automatic test_config;
    logic ack; logic [31:0] rd;
    bus_op(1'b1, 8'h0C, 32'd0, ack, rd);
    n_vec++; if (sm_div[47:24] !== 24'd1) begin n_err++; $display("FAIL div_zero: got %h want 1", sm_div[47:24]); end
    bus_op(1'b0, 8'h0C, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL div_zero_rd: got %h want 1", rd); end
    bus_op(1'b1, 8'h0C, 32'hFF12_3456, ack, rd);
    n_vec++; if (sm_div[47:24] !== 24'h123456 || sm_div[23:0] !== 24'd1) begin
      n_err++; $display("FAIL div_val: got %h want 000001 in sm0 and 123456 in sm1", sm_div[47:0]); end
    bus_op(1'b1, 8'h16, 32'hFFFF_FFFF, ack, rd);
    n_vec++; if (sm_side_count[11:9] !== 3'd7 || sm_in_base[19:15] !== 5'd31) begin
      n_err++; $display("FAIL pin3: got side_cnt %h in_base %h want 7 1f", sm_side_count[11:9], sm_in_base[19:15]); end
    n_vec++; if (sm_set_count !== 12'hE00 || sm_out_base !== 20'hF8000) begin
      n_err++; $display("FAIL pin3_iso: got set_cnt %h out_base %h want e00 f8000", sm_set_count, sm_out_base); end
    bus_op(1'b1, 8'h11, 32'hFFFF_A5A5, ack, rd);
    n_vec++; if (sm_pstart[14:10] !== 5'd5 || sm_pend[14:10] !== 5'd13 || sm_jmp_pin_sel[14:10] !== 5'd9 || sm_shift_dir !== 4'b0100) begin
      n_err++; $display("FAIL exec2: got ps %h pe %h jp %h sd %h want 05 0d 09 4", sm_pstart[14:10], sm_pend[14:10], sm_jmp_pin_sel[14:10], sm_shift_dir); end
    bus_op(1'b0, 8'h11, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'h0000_A5A5) begin n_err++; $display("FAIL exec2_rd: got %h want 0000a5a5", rd); end
    bus_op(1'b0, 8'h16, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL pin3_rd: got %h want ffffffff", rd); end
  endtask

  task automatic test_enable;
    logic ack; logic [31:0] rd;
    bus_op(1'b1, 8'h00, 32'h0000_0006, ack, rd);
    n_vec++; if (sm_en !== 4'b0110) begin n_err++; $display("FAIL en_direct: got %h want 6", sm_en); end
    bus_op(1'b0, 8'h00, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'h0000_0006) begin n_err++; $display("FAIL ctrl_rd: got %h want 6", rd); end
    bus_op(1'b1, 8'h00, 32'd0, ack, rd);
    n_vec++; if (sm_en !== 4'b0000) begin n_err++; $display("FAIL en_clear: got %h want 0", sm_en); end
  endtask

  task automatic test_restart;
    logic ack; logic [31:0] rd;
    bus_op(1'b1, 8'h00, 32'h0000_0011, ack, rd);
    n_vec++; if (sm_reset !== 4'b0001 || sm_en !== 4'b0000) begin n_err++; $display("FAIL rs_t1: got rst %h en %h want 1 0", sm_reset, sm_en); end
    bus_op(1'b0, 8'h01, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL rs_status: got %h want 1", rd); end
    n_vec++; if (sm_reset !== 4'b0001 || sm_en !== 4'b0000) begin n_err++; $display("FAIL rs_t2: got rst %h en %h want 1 0", sm_reset, sm_en); end
    @(negedge clk);
    n_vec++; if (sm_reset !== 4'b0000 || sm_en !== 4'b0000) begin n_err++; $display("FAIL rs_release: got rst %h en %h want 0 0", sm_reset, sm_en); end
    @(negedge clk);
    n_vec++; if (sm_reset !== 4'b0000 || sm_en !== 4'b0001) begin n_err++; $display("FAIL rs_t4: got rst %h en %h want 0 1", sm_reset, sm_en); end
    bus_op(1'b0, 8'h00, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL rs_ctrl_rd: got %h want 1", rd); end
  endtask

  task automatic test_retrigger;
    logic ack; logic [31:0] rd;
    bus_op(1'b1, 8'h00, 32'h0000_0011, ack, rd);
    n_vec++; if (sm_reset !== 4'b0001 || sm_en !== 4'b0000) begin n_err++; $display("FAIL rt_t1: got rst %h en %h want 1 0", sm_reset, sm_en); end
    bus_op(1'b1, 8'h00, 32'h0000_0011, ack, rd);
    n_vec++; if (sm_reset !== 4'b0001) begin n_err++; $display("FAIL rt_t2: got rst %h want 1", sm_reset); end
    @(negedge clk);
    n_vec++; if (sm_reset !== 4'b0000 || sm_en !== 4'b0000) begin n_err++; $display("FAIL rt_release: got rst %h en %h want 0 0", sm_reset, sm_en); end
    @(negedge clk);
    n_vec++; if (sm_en !== 4'b0001) begin n_err++; $display("FAIL rt_t4: got en %h want 1", sm_en); end
    bus_op(1'b1, 8'h00, 32'h0000_00C5, ack, rd);
    n_vec++; if (sm_reset !== 4'b1100 || sm_en !== 4'b0001) begin n_err++; $display("FAIL multi_t1: got rst %h en %h want c 1", sm_reset, sm_en); end
    repeat (3) @(negedge clk);
    n_vec++; if (sm_reset !== 4'b0000 || sm_en !== 4'b0101) begin n_err++; $display("FAIL multi_t4: got rst %h en %h want 0 5", sm_reset, sm_en); end
  endtask

  task automatic test_unmapped;
    logic ack; logic [31:0] rd;
    bus_op(1'b0, 8'h05, 32'd0, ack, rd);
    n_vec++; if (ack !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL um_rd05: got ack %h data %h want 1 0", ack, rd); end
    bus_op(1'b0, 8'h30, 32'd0, ack, rd);
    n_vec++; if (ack !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL um_rd30: got ack %h data %h want 1 0", ack, rd); end
    bus_op(1'b1, 8'h0B, 32'hFFFF_FFFF, ack, rd);
    bus_op(1'b1, 8'h18, 32'hFFFF_FFFF, ack, rd);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL um_wr_ack: got %h want 1", ack); end
    bus_op(1'b0, 8'h0B, 32'd0, ack, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL um_rd0b: got %h want 0", rd); end
    n_vec++; if (sm_div !== {24'd1, 24'd1, 24'h123456, 24'd1} || sm_pin_ok() !== 1'b1) begin
      n_err++; $display("FAIL um_regs: got div %h out_base %h want unchanged", sm_div, sm_out_base); end
  endtask

  function automatic logic sm_pin_ok();
    return (sm_out_base == 20'hF8000) && (sm_side_count == 12'hE00);
  endfunction

  task automatic test_async_reset;
    logic ack; logic [31:0] rd;
    bus_op(1'b1, 8'h00, 32'h0000_0011, ack, rd);
    n_vec++; if (sm_reset !== 4'b0001) begin n_err++; $display("FAIL ar_hold: got rst %h want 1", sm_reset); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (sm_reset !== 4'b0000 || sm_en !== 4'b0000 || bus_ack !== 1'b0) begin
      n_err++; $display("FAIL ar_immediate: got rst %h en %h ack %h want 0 0 0", sm_reset, sm_en, bus_ack); end
    n_vec++; if (sm_div[47:24] !== 24'd1 || sm_out_base !== 20'd0) begin
      n_err++; $display("FAIL ar_cfg: got div1 %h out_base %h want 1 0", sm_div[47:24], sm_out_base); end
    @(negedge clk);
    reset = 1'b0;
    bus_op(1'b0, 8'h01, 32'd0, ack, rd);
    n_vec++; if (ack !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL ar_status: got ack %h data %h want 1 0", ack, rd); end
    n_vec++; if (sm_reset !== 4'b0000 || sm_en !== 4'b0000) begin n_err++; $display("FAIL ar_after: got rst %h en %h want 0 0", sm_reset, sm_en); end
  endtask

  initial begin
    test_reset;
    test_instr;
    test_config;
    test_enable;
    test_restart;
    test_retrigger;
    test_unmapped;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
